// File: rtl/seq_shift_add_multiplier.sv
// -----------------------------------------------------------------------------
// seq_shift_add_multiplier
//
// Sequential shift-and-add multiplier. One multiplier bit is consumed per
// clock. Signed operands are reduced to magnitudes at accept time, the
// magnitudes are multiplied unsigned, and the recorded sign is applied to the
// final sum as it is written into the product register.
//
// Parameters
//   M          multiplicand width (>= 2)
//   N          multiplier width (>= 2)
//   EARLY_TERM 1 = stop as soon as no set multiplier bits remain
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   operands valid
//   in_ready   block can accept operands (IDLE and not in reset)
//   a          multiplicand, M bits
//   b          multiplier, N bits
//   sgn        1 = a and b are two's complement, 0 = unsigned
//   abort      synchronous cancel of the operation in flight
//   out_valid  product valid (DONE state)
//   out_ready  consumer accepts the product
//   product    M+N bit result, held until the next completed operation
// -----------------------------------------------------------------------------
module seq_shift_add_multiplier #(
  parameter int M          = 8,
  parameter int N          = 8,
  parameter int EARLY_TERM = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [M-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           sgn,
  input  logic           abort,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [M+N-1:0] product
);

  localparam int W  = M + N;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_next;

  logic [W-1:0]   acc;
  logic [W-1:0]   a_shift;   // |a| << count, kept pre-shifted
  logic [N-1:0]   b_rem;     // |b| >> count; bit 0 is the bit processed now
  logic [CW-1:0]  count;
  logic           neg;

  logic           a_neg;
  logic           b_neg;
  logic [M-1:0]   a_mag;
  logic [N-1:0]   b_mag;

  logic           accept;
  logic           step;
  logic           last;
  logic [W-1:0]   acc_sum;
  logic [W-1:0]   result;

  // Magnitudes. The most negative value maps to 2^(M-1) / 2^(N-1), which
  // still fits the unsigned M / N bit field, so no extra bit is needed.
  assign a_neg = sgn & a[M-1];
  assign b_neg = sgn & b[N-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // Datapath for the current RUN cycle.
  always_comb begin
    acc_sum = b_rem[0] ? (acc + a_shift) : acc;
    result  = neg ? -acc_sum : acc_sum;

    // The last bit is either bit N-1, or (early termination) the bit after
    // which no set bits remain. b = 0 therefore still takes one cycle.
    last = (count == CW'(N - 1));
    if (EARLY_TERM != 0 && b_rem[N-1:1] == '0) begin
      last = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and control strobes
  // abort beats both completion and the output handshake, and blocks an
  // accept in IDLE.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    step       = 1'b0;

    case (state)
      IDLE: begin
        if (in_valid && !abort) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_next = IDLE;
        end else begin
          step = 1'b1;
          if (last) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (abort || out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      a_shift <= '0;
      b_rem   <= '0;
      count   <= '0;
      neg     <= 1'b0;
      product <= '0;
    end else begin
      if (accept) begin
        acc     <= '0;
        a_shift <= W'(a_mag);
        b_rem   <= b_mag;
        count   <= '0;
        neg     <= a_neg ^ b_neg;
      end else if (step) begin
        acc     <= acc_sum;
        a_shift <= a_shift << 1;
        b_rem   <= b_rem >> 1;
        count   <= count + CW'(1);
        // product only changes on the edge that enters DONE
        if (last) begin
          product <= result;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// -----------------------------------------------------------------------------
// tb_seq_shift_add_multiplier
//
// Two 8x8 instances: index 0 with EARLY_TERM=0, index 1 with EARLY_TERM=1.
// Directed steps followed by random operations, checked against an
// arithmetic reference model (integer product and highest-set-bit latency).
// -----------------------------------------------------------------------------
module tb_seq_shift_add_multiplier;

  logic        clk;
  logic        rst;

  logic        in_valid_v  [2];
  logic        in_ready_v  [2];
  logic [7:0]  a_v         [2];
  logic [7:0]  b_v         [2];
  logic        sgn_v       [2];
  logic        abort_v     [2];
  logic        out_valid_v [2];
  logic        out_ready_v [2];
  logic [15:0] product_v   [2];

  logic [15:0] exp_last    [2];

  int total;
  int bad;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      seq_shift_add_multiplier #(
        .M          (8),
        .N          (8),
        .EARLY_TERM (gi)
      ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid_v[gi]),
        .in_ready  (in_ready_v[gi]),
        .a         (a_v[gi]),
        .b         (b_v[gi]),
        .sgn       (sgn_v[gi]),
        .abort     (abort_v[gi]),
        .out_valid (out_valid_v[gi]),
        .out_ready (out_ready_v[gi]),
        .product   (product_v[gi])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic longint val8(input logic [7:0] x, input logic s);
    longint v;
    v = longint'(x);
    if (s && x[7]) v = v - 256;
    return v;
  endfunction

  function automatic logic [15:0] ref_prod(input logic [7:0] x, input logic [7:0] y,
                                           input logic s);
    logic [63:0] full;
    full = 64'(val8(x, s) * val8(y, s));
    return full[15:0];
  endfunction

  function automatic int ref_lat(input int idx, input logic [7:0] y, input logic s);
    longint mag;
    int lat;
    if (idx == 0) return 8;
    mag = val8(y, s);
    if (mag < 0) mag = -mag;
    lat = 1;
    for (int i = 0; i < 9; i++) begin
      if (((mag >> i) & 1) != 0) lat = i + 1;
    end
    return lat;
  endfunction

  // ---------------------------------------------------------------------------
  // Checking helper
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Operation tasks (all called at a negedge, return at a negedge)
  // ---------------------------------------------------------------------------
  task automatic start_op(input int idx, input logic [7:0] av, input logic [7:0] bv,
                          input logic sv, input string tag);
    for (int i = 0; i < 20 && !in_ready_v[idx]; i++) @(negedge clk);
    chk({tag, "_rdy"}, 32'(in_ready_v[idx]), 32'd1);
    a_v[idx]      = av;
    b_v[idx]      = bv;
    sgn_v[idx]    = sv;
    in_valid_v[idx] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // scramble the inputs: the operation in flight must not see them
    in_valid_v[idx] = 1'b0;
    a_v[idx]      = 8'($urandom);
    b_v[idx]      = 8'($urandom);
    sgn_v[idx]    = 1'($urandom);
    chk({tag, "_keep"}, 32'(product_v[idx]), 32'(exp_last[idx]));
  endtask

  task automatic wait_done(input int idx, input logic [15:0] exp_p, input int exp_lat,
                           input string tag);
    int lat;
    lat = 0;
    while (!out_valid_v[idx] && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (!out_valid_v[idx])
        chk({tag, "_keep_run"}, 32'(product_v[idx]), 32'(exp_last[idx]));
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_prod"}, 32'(product_v[idx]), 32'(exp_p));
    exp_last[idx] = exp_p;
  endtask

  task automatic finish_op(input int idx, input int hold, input logic [15:0] exp_p,
                           input string tag);
    for (int k = 0; k < hold; k++) begin
      in_valid_v[idx] = k[0];
      a_v[idx]        = 8'($urandom);
      b_v[idx]        = 8'($urandom);
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_hold_ov"}, 32'(out_valid_v[idx]), 32'd1);
      chk({tag, "_hold_p"}, 32'(product_v[idx]), 32'(exp_p));
    end
    in_valid_v[idx]  = 1'b0;
    out_ready_v[idx] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready_v[idx] = 1'b0;
    chk({tag, "_ov_drop"}, 32'(out_valid_v[idx]), 32'd0);
    chk({tag, "_idle"}, 32'(in_ready_v[idx]), 32'd1);
  endtask

  task automatic do_op(input int idx, input logic [7:0] av, input logic [7:0] bv,
                       input logic sv, input logic [15:0] exp_p, input int exp_lat,
                       input int hold, input string tag);
    start_op(idx, av, bv, sv, tag);
    wait_done(idx, exp_p, exp_lat, tag);
    finish_op(idx, hold, exp_p, tag);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic        rs;
    int          idx;

    total = 0;
    bad   = 0;
    rst   = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid_v[i]  = 1'b0;
      a_v[i]         = '0;
      b_v[i]         = '0;
      sgn_v[i]       = 1'b0;
      abort_v[i]     = 1'b0;
      out_ready_v[i] = 1'b0;
      exp_last[i]    = '0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_in_ready", 32'(in_ready_v[i]), 32'd0);
      chk("rst_out_valid", 32'(out_valid_v[i]), 32'd0);
      chk("rst_product", 32'(product_v[i]), 32'd0);
    end
    rst = 1'b0;
    #1;
    chk("rel_in_ready0", 32'(in_ready_v[0]), 32'd1);
    chk("rel_in_ready1", 32'(in_ready_v[1]), 32'd1);
    @(negedge clk);

    // Directed vectors, EARLY_TERM=0
    do_op(0, 8'd255, 8'd255, 1'b0, 16'hFE01, 8, 0, "u255x255");
    do_op(0, 8'h80, 8'h80, 1'b1, 16'h4000, 8, 0, "s_min_x_min");
    do_op(0, 8'h80, 8'h01, 1'b1, 16'hFF80, 8, 0, "s_min_x_1");
    do_op(0, 8'h05, 8'hFD, 1'b1, 16'hFFF1, 8, 0, "s5_x_m3");

    // Directed vectors, EARLY_TERM=1
    do_op(1, 8'd7, 8'h04, 1'b0, 16'd28, 3, 0, "et_7x4");
    do_op(1, 8'd7, 8'h00, 1'b0, 16'd0, 1, 0, "et_7x0");
    do_op(1, 8'h80, 8'h80, 1'b1, 16'h4000, 8, 0, "et_min_x_min");

    // DONE held for 5 cycles with in_valid toggling, then a fresh operation
    do_op(0, 8'd13, 8'd11, 1'b0, 16'd143, 8, 5, "hold5");
    do_op(0, 8'd3, 8'd9, 1'b0, 16'd27, 8, 0, "after_hold");

    // abort at the 4th RUN edge
    start_op(0, 8'd100, 8'd200, 1'b0, "abort_run");
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    abort_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort_v[0] = 1'b0;
    chk("abort_run_ov", 32'(out_valid_v[0]), 32'd0);
    chk("abort_run_idle", 32'(in_ready_v[0]), 32'd1);
    chk("abort_run_prod", 32'(product_v[0]), 32'(exp_last[0]));
    do_op(0, 8'd21, 8'd12, 1'b0, 16'd252, 8, 0, "after_abort");

    // abort in DONE beats out_ready
    start_op(1, 8'hFF, 8'h02, 1'b1, "abort_done");
    wait_done(1, 16'hFFFE, 2, "abort_done");
    abort_v[1]     = 1'b1;
    out_ready_v[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort_v[1]     = 1'b0;
    out_ready_v[1] = 1'b0;
    chk("abort_done_ov", 32'(out_valid_v[1]), 32'd0);
    chk("abort_done_idle", 32'(in_ready_v[1]), 32'd1);
    chk("abort_done_prod", 32'(product_v[1]), 32'hFFFE);

    // abort in IDLE blocks an accept
    in_valid_v[0] = 1'b1;
    abort_v[0]    = 1'b1;
    a_v[0]        = 8'd9;
    b_v[0]        = 8'd9;
    @(posedge clk);
    @(negedge clk);
    in_valid_v[0] = 1'b0;
    abort_v[0]    = 1'b0;
    chk("abort_idle_ready", 32'(in_ready_v[0]), 32'd1);
    repeat (9) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("abort_idle_ov", 32'(out_valid_v[0]), 32'd0);

    // asynchronous reset pulse in the middle of RUN
    start_op(0, 8'd77, 8'd55, 1'b0, "rst_run");
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    chk("rst_run_prod", 32'(product_v[0]), 32'd0);
    chk("rst_run_ov", 32'(out_valid_v[0]), 32'd0);
    chk("rst_run_ready", 32'(in_ready_v[0]), 32'd0);
    exp_last[0] = '0;
    exp_last[1] = '0;
    @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_rel_ready", 32'(in_ready_v[0]), 32'd1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("rst_no_ov", 32'(out_valid_v[0]), 32'd0);
    end
    chk("rst_rel_ready2", 32'(in_ready_v[0]), 32'd1);

    // Random operations on both instances
    for (int i = 0; i < 40; i++) begin
      idx = i % 2;
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      if ((i % 5) == 1) rb = 8'($urandom_range(0, 15));
      rs  = 1'($urandom);
      do_op(idx, ra, rb, rs, ref_prod(ra, rb, rs), ref_lat(idx, rb, rs),
            int'($urandom_range(0, 2)), $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
